// File: rtl/alu_seq_core_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_seq_core_if                                                 |
// | Purpose  : Request/response bundle for alu_seq_core. The request side       |
// |            carries the decode fields and operands. The response side        |
// |            carries the result and its flags.                                |
// | Ports    : master - drives in_valid/alu_op/funct/a/b/out_ready              |
// |            slave  - drives in_ready/out_valid/result/carry/zero/sign/illegal|
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface alu_seq_core_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_op;
  logic [5:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             sign;
  logic             illegal;

  modport master (
    output in_valid, alu_op, funct, a, b, out_ready,
    input  in_ready, out_valid, result, carry, zero, sign, illegal
  );

  modport slave (
    input  in_valid, alu_op, funct, a, b, out_ready,
    output in_ready, out_valid, result, carry, zero, sign, illegal
  );
endinterface
`default_nettype wire

// File: rtl/alu_seq_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_seq_core                                                    |
// | Purpose  : Multi-cycle ALU with built-in alu_op/funct decode. Shifts run    |
// |            one bit per cycle. Operands arrive and results leave over        |
// |            valid/ready handshakes.                                          |
// | Ports    : clk  - rising-edge clock                                        |
// |            rst  - asynchronous active-high reset                           |
// |            bus  - alu_seq_core_if.slave (request + response handshakes)    |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module alu_seq_core #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input wire logic      clk,
  input wire logic      rst,
  alu_seq_core_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd2} state_e;
  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_COMP = 3'd1, OP_AND = 3'd2, OP_XOR = 3'd3,
    OP_DIFF = 3'd4, OP_SLL = 3'd5, OP_SRL = 3'd6, OP_SRA = 3'd7
  } op_e;

  state_e           r_state, w_state_nxt;
  op_e              r_op, w_op;
  logic             w_illegal;
  logic [WIDTH-1:0] r_res;
  logic [SHW-1:0]   r_cnt;
  logic             r_carry, r_zero, r_sign, r_illegal;

  logic [SHW-1:0]   w_shamt;
  logic             w_is_shift;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_carry;
  logic [WIDTH-1:0] w_sh_res;
  logic             w_sh_out;
  logic             w_accept, w_start_shift, w_finish_shift;

  // Operation decode. Undefined combinations execute add and flag illegal.
  always_comb begin
    w_op      = OP_ADD;
    w_illegal = 1'b0;
    case (bus.alu_op)
      3'b000: w_op = OP_ADD;
      3'b001: w_op = OP_SLL;
      3'b010: w_op = OP_SRL;
      3'b011: w_op = OP_SRA;
      3'b100: w_op = OP_COMP;
      3'b101: w_op = OP_DIFF;
      3'b111: begin
        case (bus.funct)
          6'd1:    w_op = OP_ADD;
          6'd2:    w_op = OP_COMP;
          6'd3:    w_op = OP_AND;
          6'd4:    w_op = OP_XOR;
          6'd5:    w_op = OP_DIFF;
          6'd6:    w_op = OP_SLL;
          6'd7:    w_op = OP_SRL;
          6'd8:    w_op = OP_SRA;
          default: w_illegal = 1'b1;
        endcase
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_shamt    = bus.b[SHW-1:0];
  assign w_is_shift = (w_op == OP_SLL) || (w_op == OP_SRL) || (w_op == OP_SRA);
  assign w_sum      = {1'b0, bus.a} + {1'b0, bus.b};
  assign w_x        = bus.a ^ bus.b;

  // Scanning from the top down means the last hit is the lowest set bit.
  always_comb begin
    w_diff = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (w_x[i]) w_diff = WIDTH'(i + 1);
    end
  end

  // Single-cycle results. A shift reaching this path has s == 0, so it passes a through.
  always_comb begin
    w_alu_res   = bus.a;
    w_alu_carry = 1'b0;
    case (w_op)
      OP_ADD:  begin
        w_alu_res   = w_sum[WIDTH-1:0];
        w_alu_carry = w_sum[WIDTH];
      end
      OP_COMP: w_alu_res = ~bus.b + WIDTH'(1);
      OP_AND:  w_alu_res = bus.a & bus.b;
      OP_XOR:  w_alu_res = bus.a ^ bus.b;
      OP_DIFF: w_alu_res = w_diff;
      default: w_alu_res = bus.a;
    endcase
  end

  // One-bit shift step on the working register.
  always_comb begin
    w_sh_res = r_res;
    w_sh_out = 1'b0;
    case (r_op)
      OP_SLL: begin
        w_sh_res = {r_res[WIDTH-2:0], 1'b0};
        w_sh_out = r_res[WIDTH-1];
      end
      OP_SRL: begin
        w_sh_res = {1'b0, r_res[WIDTH-1:1]};
        w_sh_out = r_res[0];
      end
      OP_SRA: begin
        w_sh_res = {r_res[WIDTH-1], r_res[WIDTH-1:1]};
        w_sh_out = r_res[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_accept       = 1'b0;
    w_start_shift  = 1'b0;
    w_finish_shift = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          w_accept = 1'b1;
          if (w_is_shift && (w_shamt != '0)) begin
            w_start_shift = 1'b1;
            w_state_nxt   = ST_SHIFT;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        if (r_cnt == SHW'(1)) begin
          w_finish_shift = 1'b1;
          w_state_nxt    = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: r_res is the shift working register and, in DONE, the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op      <= OP_ADD;
      r_res     <= '0;
      r_cnt     <= '0;
      r_carry   <= 1'b0;
      r_zero    <= 1'b0;
      r_sign    <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_op      <= w_op;
      r_illegal <= w_illegal;
      r_cnt     <= w_shamt;
      if (w_start_shift) begin
        r_res   <= bus.a;
        r_carry <= 1'b0;
      end else begin
        r_res   <= w_alu_res;
        r_carry <= w_alu_carry;
        r_zero  <= (w_alu_res == '0);
        r_sign  <= w_alu_res[WIDTH-1];
      end
    end else if (r_state == ST_SHIFT) begin
      r_res   <= w_sh_res;
      r_carry <= w_sh_out;
      r_cnt   <= r_cnt - SHW'(1);
      if (w_finish_shift) begin
        r_zero <= (w_sh_res == '0);
        r_sign <= w_sh_res[WIDTH-1];
      end
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.result    = r_res;
  assign bus.carry     = r_carry;
  assign bus.zero      = r_zero;
  assign bus.sign      = r_sign;
  assign bus.illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_alu_seq_core                                                 |
// | Purpose  : Self-checking bench for alu_seq_core. It runs directed vectors, |
// |            back-pressure and reset sequences, and random ops compared to a |
// |            behavioural model.                                              |
// | Ports    : none                                                            |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_alu_seq_core;

  localparam int WIDTH = 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;

  alu_seq_core_if #(.WIDTH(WIDTH)) bus ();

  alu_seq_core #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        c;
    logic        z;
    logic        s;
    logic        il;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model derived from the operation rules, using whole-word arithmetic.
  function automatic void model(input logic [2:0] op, input logic [5:0] fn,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic c, output logic z,
                                output logic s, output logic il, output int lat);
    string kind;
    logic [32:0] sum;
    logic [31:0] x;
    int sh;
    il = 1'b0;
    kind = "add";
    if (op == 3'd7) begin
      case (fn)
        6'd1: kind = "add";  6'd2: kind = "comp"; 6'd3: kind = "and";
        6'd4: kind = "xor";  6'd5: kind = "diff"; 6'd6: kind = "sll";
        6'd7: kind = "srl";  6'd8: kind = "sra";
        default: il = 1'b1;
      endcase
    end else begin
      case (op)
        3'd0: kind = "add"; 3'd1: kind = "sll"; 3'd2: kind = "srl";
        3'd3: kind = "sra"; 3'd4: kind = "comp"; 3'd5: kind = "diff";
        default: il = 1'b1;
      endcase
    end
    sh = int'(b % 32);
    c = 1'b0;
    r = a;
    lat = 1;
    if (kind == "add") begin
      sum = {1'b0, a} + {1'b0, b};
      r = sum[31:0];
      c = sum[32];
    end else if (kind == "comp") r = 32'd0 - b;
    else if (kind == "and") r = a & b;
    else if (kind == "xor") r = a ^ b;
    else if (kind == "diff") begin
      r = 0;
      x = a ^ b;
      for (int i = 31; i >= 0; i--) if (x[i]) r = i + 1;
    end else begin
      if (kind == "sll") begin
        r = a << sh;
        c = (sh == 0) ? 1'b0 : a[32 - sh];
      end else if (kind == "srl") begin
        r = a >> sh;
        c = (sh == 0) ? 1'b0 : a[sh - 1];
      end else begin
        r = $signed(a) >>> sh;
        c = (sh == 0) ? 1'b0 : a[sh - 1];
      end
      if (sh != 0) lat = 1 + sh;
    end
    z = (r == 0);
    s = r[31];
  endfunction

  // Issues one op, measures latency, captures outputs and completes the result handshake.
  task automatic run_op(input logic [2:0] op, input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input bit early,
                        output logic [31:0] r, output logic c, output logic z,
                        output logic s, output logic il, output int lat, output logic rdy_after);
    bus.alu_op = op; bus.funct = fn; bus.a = a; bus.b = b;
    bus.in_valid = 1'b1;
    bus.out_ready = early;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a = $urandom; bus.b = $urandom;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.out_valid) lat = -1;
    r = bus.result; c = bus.carry; z = bus.zero; s = bus.sign; il = bus.illegal;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    rdy_after = bus.in_ready;
  endtask

  task automatic check_op(input string tag, input logic [31:0] r, input logic c, input logic z,
                          input logic s, input logic il, input int lat, input logic rdy,
                          input logic [31:0] er, input logic ec, input logic ez,
                          input logic es, input logic eil, input int elat);
    chk({tag, " result"}, 64'(r), 64'(er));
    chk({tag, " carry"}, 64'(c), 64'(ec));
    chk({tag, " zero"}, 64'(z), 64'(ez));
    chk({tag, " sign"}, 64'(s), 64'(es));
    chk({tag, " illegal"}, 64'(il), 64'(eil));
    chk({tag, " latency"}, 64'(lat), 64'(elat));
    chk({tag, " in_ready_after"}, 64'(rdy), 64'(1));
  endtask

  initial begin
    logic [31:0] r, er, ra, rb;
    logic c, z, s, il, rdy, ec, ez, es, eil;
    logic [2:0] rop;
    logic [5:0] rfn;
    int lat, elat;
    bit seen;

    n_checks = 0;
    n_err = 0;
    //          op     fn     a             b             result        c     z     s     il    lat
    vecs[0]  = '{3'd0, 6'd0, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1};
    vecs[1]  = '{3'd3, 6'd0, 32'h80000001, 32'h4,        32'hF8000000, 1'b0, 1'b0, 1'b1, 1'b0, 5};
    vecs[2]  = '{3'd3, 6'd0, 32'h80000001, 32'h0,        32'h80000001, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[3]  = '{3'd7, 6'd5, 32'h10,       32'h30,       32'h6,        1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[4]  = '{3'd7, 6'd5, 32'h1234,     32'h1234,     32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1};
    vecs[5]  = '{3'd7, 6'd9, 32'h2,        32'h3,        32'h5,        1'b0, 1'b0, 1'b0, 1'b1, 1};
    vecs[6]  = '{3'd0, 6'd0, 32'h7,        32'h8,        32'hF,        1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[7]  = '{3'd7, 6'd3, 32'hF0F0,     32'hFF00,     32'hF000,     1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[8]  = '{3'd4, 6'd0, 32'h0,        32'h1,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[9]  = '{3'd7, 6'd6, 32'h1,        32'd31,       32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0, 32};
    vecs[10] = '{3'd2, 6'd0, 32'h3,        32'h1,        32'h1,        1'b1, 1'b0, 1'b0, 1'b0, 2};
    vecs[11] = '{3'd7, 6'd4, 32'hF0,       32'hFF,       32'h0F,       1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[12] = '{3'd6, 6'd0, 32'h1,        32'h1,        32'h2,        1'b0, 1'b0, 1'b0, 1'b1, 1};
    vecs[13] = '{3'd1, 6'd0, 32'h80000000, 32'h1,        32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 2};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.alu_op = 3'd0; bus.funct = 6'd0; bus.a = '0; bus.b = '0;
    #1;
    chk("reset in_ready", 64'(bus.in_ready), 64'(1));
    chk("reset out_valid", 64'(bus.out_valid), 64'(0));
    chk("reset result", 64'(bus.result), 64'(0));
    chk("reset flags", 64'({bus.carry, bus.zero, bus.sign, bus.illegal}), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].fn, vecs[i].a, vecs[i].b, 1'b0, r, c, z, s, il, lat, rdy);
      check_op($sformatf("vec%0d", i), r, c, z, s, il, lat, rdy,
               vecs[i].r, vecs[i].c, vecs[i].z, vecs[i].s, vecs[i].il, vecs[i].lat);
    end

    // Back-pressure: result held while out_ready stays low; a new request is ignored.
    bus.alu_op = 3'd7; bus.funct = 6'd3; bus.a = 32'hF0F0; bus.b = 32'hFF00;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin
        bus.alu_op = 3'd0; bus.a = 32'h1; bus.b = 32'h1; bus.in_valid = 1'b1;
      end
      if (k == 8) bus.in_valid = 1'b0;
      chk($sformatf("bp result c%0d", k), 64'(bus.result), 64'(32'hF000));
      chk($sformatf("bp out_valid c%0d", k), 64'(bus.out_valid), 64'(1));
      chk($sformatf("bp in_ready c%0d", k), 64'(bus.in_ready), 64'(0));
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("bp release in_ready", 64'(bus.in_ready), 64'(1));
    chk("bp release out_valid", 64'(bus.out_valid), 64'(0));
    @(posedge clk);
    #1;
    chk("bp ignored request", 64'(bus.out_valid), 64'(0));

    // Reset in the middle of a 31-step shift.
    bus.alu_op = 3'd1; bus.a = 32'h1; bus.b = 32'd31; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("midshift busy", 64'({bus.in_ready, bus.out_valid}), 64'(0));
    rst = 1'b1;
    #1;
    chk("midreset in_ready", 64'(bus.in_ready), 64'(1));
    chk("midreset out_valid", 64'(bus.out_valid), 64'(0));
    chk("midreset result", 64'(bus.result), 64'(0));
    chk("midreset flags", 64'({bus.carry, bus.zero, bus.sign, bus.illegal}), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("aborted op no out_valid", 64'(seen), 64'(0));
    run_op(3'd0, 6'd0, 32'd100, 32'd23, 1'b0, r, c, z, s, il, lat, rdy);
    check_op("post-reset add", r, c, z, s, il, lat, rdy, 32'd123, 1'b0, 1'b0, 1'b0, 1'b0, 1);

    // Random ops against the model, with out_ready sometimes already high.
    for (int n = 0; n < 200; n++) begin
      rop = 3'($urandom_range(0, 7));
      rfn = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(1, 8));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
      model(rop, rfn, ra, rb, er, ec, ez, es, eil, elat);
      run_op(rop, rfn, ra, rb, 1'($urandom_range(0, 1)), r, c, z, s, il, lat, rdy);
      check_op($sformatf("rnd%0d op%0d fn%0d a%0h b%0h", n, rop, rfn, ra, rb),
               r, c, z, s, il, lat, rdy, er, ec, ez, es, eil, elat);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
